display_page_sequencer: RTL

Sequences the page shown by the four-digit seven-segment display controller. It drives that controller's page selects (`state_led`, `last_led`), choosing one of four 16-bit pages: TX low pair, TX high pair, RX low pair or RX high pair. Pages change on a debounced push-button, on an optional auto-rotate timer, or on UART buffer events. It sits between the board buttons, the UART TX/RX buffer logic, and the display controller.

---
 rtl/display_page_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/display_page_sequencer.sv
// ---------------------------------------------------------------------------
// display_page_sequencer
//
// Chooses which 16-bit page the four-digit seven-segment display controller
// shows. The four pages are the low/high byte pairs of the TX and RX buffers,
// and they are selected through {last_led, state_led}. The page advances on a
// debounced "next" button, jumps to a fixed page on UART buffer events, and can
// optionally auto-rotate on a dwell timer toggled by a second button.
//
// Build option:
//   PAGE_SEQ_AUTO_ROTATE_EN  when defined, compiles in the auto-rotate timer and
//                            the btn_mode debouncer/toggle. When undefined,
//                            btn_mode is ignored and auto_led is tied to 0.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a synchronized button level must stay stable
//   ROTATE_CYCLES    auto-rotate dwell per page, in cycles
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn_next     raw asynchronous "next page" button, active high
//   btn_mode     raw asynchronous auto-rotate toggle button, active high
//   tx_load      one-cycle pulse: TX buffer written      -> jump to TX low pair
//   rx_done      one-cycle pulse: RX buffer 4-byte fill  -> jump to RX low pair
//   state_led    page half: 2'b01 = bytes 1:0, 2'b10 = bytes 3:2
//   last_led     buffer select: 0 = TX, 1 = RX
//   auto_led     high while auto-rotate is active
//   page_change  one-cycle pulse whenever the page outputs change
// ---------------------------------------------------------------------------
module display_page_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ROTATE_CYCLES   = 200000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_mode,
  input  logic       tx_load,
  input  logic       rx_done,
  output logic [1:0] state_led,
  output logic       last_led,
  output logic       auto_led,
  output logic       page_change
);

  // -------------------------------------------------------------------------
  // Button front ends
  // -------------------------------------------------------------------------
  localparam int            DW      = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter is compared against one less than the threshold so that the
  // accept happens on the very edge at which the count would reach it.
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

`ifdef PAGE_SEQ_AUTO_ROTATE_EN
  localparam int NBTN = 2;
  logic [NBTN-1:0] btn_raw;
  assign btn_raw = {btn_mode, btn_next};
`else
  localparam int NBTN = 1;
  logic [NBTN-1:0] btn_raw;
  assign btn_raw = btn_next;
  // btn_mode has no function in this build.
  logic unused_btn_mode;
  assign unused_btn_mode = btn_mode;
`endif

  // One registered rising-edge event per button (bit 0 = next, bit 1 = mode).
  logic [NBTN-1:0] btn_evt;

  generate
    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
      logic [1:0]    sync_reg;
      logic [DW-1:0] cnt_reg;
      logic          level_reg;
      logic          level_prev_reg;
      logic          evt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg       <= 2'b00;
          cnt_reg        <= '0;
          level_reg      <= 1'b0;
          level_prev_reg <= 1'b0;
          evt_reg        <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[0], btn_raw[gi]};

          // Any return to the accepted level restarts the stability window,
          // so glitches shorter than the window never get through.
          if (sync_reg[1] == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            cnt_reg   <= '0;
            level_reg <= sync_reg[1];
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end

          // Edge detect on the accepted level; a held button yields one event.
          level_prev_reg <= level_reg;
          evt_reg        <= level_reg & ~level_prev_reg;
        end
      end

      assign btn_evt[gi] = evt_reg;
    end
  endgenerate

  logic next_evt;
  assign next_evt = btn_evt[0];

  // -------------------------------------------------------------------------
  // Page selection
  // -------------------------------------------------------------------------
  // Encoding is {last_led, state_led} so the outputs come straight off the
  // state register.
  typedef enum logic [2:0] {
    TX_LO = 3'b001,
    TX_HI = 3'b010,
    RX_LO = 3'b101,
    RX_HI = 3'b110
  } page_t;

  page_t page_reg;
  page_t page_next;
  logic  page_evt;
  logic  page_change_reg;
  logic  rot_tick;

  function automatic page_t step_page(input page_t p);
    case (p)
      TX_LO:   return TX_HI;
      TX_HI:   return RX_LO;
      RX_LO:   return RX_HI;
      default: return TX_LO;
    endcase
  endfunction

  // Exactly one source wins per cycle; lower-priority requests in the same
  // cycle are simply dropped.
  always_comb begin
    page_next = page_reg;
    page_evt  = 1'b0;
    if (rx_done) begin
      page_next = RX_LO;
      page_evt  = 1'b1;
    end else if (tx_load) begin
      page_next = TX_LO;
      page_evt  = 1'b1;
    end else if (next_evt || rot_tick) begin
      page_next = step_page(page_reg);
      page_evt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_reg        <= TX_LO;
      page_change_reg <= 1'b0;
    end else begin
      page_change_reg <= 1'b0;
      if (page_evt) begin
        page_reg        <= page_next;
        // A jump to the page already shown is still an event (it restarts the
        // dwell) but must not pulse page_change.
        page_change_reg <= (page_next != page_reg);
      end
    end
  end

  assign state_led   = page_reg[1:0];
  assign last_led    = page_reg[2];
  assign page_change = page_change_reg;

  // -------------------------------------------------------------------------
  // Auto-rotate
  // -------------------------------------------------------------------------
`ifdef PAGE_SEQ_AUTO_ROTATE_EN
  localparam int            RW       = $clog2(ROTATE_CYCLES + 1);
  localparam logic [RW-1:0] ROT_LAST = RW'(ROTATE_CYCLES - 1);

  logic          mode_evt;
  logic          auto_reg;
  logic [RW-1:0] rot_cnt_reg;

  assign mode_evt = btn_evt[1];
  assign rot_tick = auto_reg && (rot_cnt_reg == ROT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_reg    <= 1'b0;
      rot_cnt_reg <= '0;
    end else begin
      if (mode_evt) begin
        auto_reg <= ~auto_reg;
      end
      // rot_tick always produces a page event, so the wrap to zero is covered
      // by the same clear that restarts the dwell on any other page event.
      if (mode_evt || page_evt) begin
        rot_cnt_reg <= '0;
      end else if (auto_reg) begin
        rot_cnt_reg <= rot_cnt_reg + 1'b1;
      end
    end
  end

  assign auto_led = auto_reg;
`else
  assign rot_tick = 1'b0;
  assign auto_led = 1'b0;
`endif

endmodule
